// File: rtl/mem_resp_router_if.sv
// Bundle for the return path of the memory port: the issue-side tag handshake,
// the memory response channel and the two requester response channels.
interface mem_resp_router_if #(
    parameter int n = 32
);
    logic         iss_valid;
    logic         iss_sel;
    logic         iss_ready;
    logic         rsp_valid;
    logic [n-1:0] rsp_data;
    logic         rsp_ready;
    logic         a_valid;
    logic [n-1:0] a_data;
    logic         a_ready;
    logic         b_valid;
    logic [n-1:0] b_data;
    logic         b_ready;

    // Issue logic, memory and the two requesters together drive this side
    modport master (
        output iss_valid, iss_sel, rsp_valid, rsp_data, a_ready, b_ready,
        input  iss_ready, rsp_ready, a_valid, a_data, b_valid, b_data
    );

    modport slave (
        input  iss_valid, iss_sel, rsp_valid, rsp_data, a_ready, b_ready,
        output iss_ready, rsp_ready, a_valid, a_data, b_valid, b_data
    );
endinterface

// File: rtl/mem_resp_router.sv
// Steers in-order memory responses to port A (fetch) or port B (load/store)
// using a FIFO of 1-bit destination tags pushed at request issue.
module mem_resp_router #(
    parameter int n     = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    mem_resp_router_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic                         orphan_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] tag_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             orphan_r;

    logic [CW-1:0]    count_next_s;
    logic [n-1:0]     rsp_data_s;
    logic             empty_s;
    logic             full_s;
    logic             head_s;
    logic             push_s;
    logic             pop_s;
    logic             orphan_s;

    assign empty_s    = (count_r == CW'(0));
    assign full_s     = (count_r == CW'(DEPTH));
    assign head_s     = tag_r[rd_ptr_r];
    assign rsp_data_s = bus.rsp_data;

    // A full FIFO refuses the push even if a pop frees a slot this cycle
    assign push_s   = bus.iss_valid && !full_s;
    assign pop_s    = bus.rsp_valid && bus.rsp_ready && !empty_s;
    assign orphan_s = bus.rsp_valid && empty_s;

    assign bus.iss_ready = !full_s;
    assign bus.a_data    = rsp_data_s;
    assign bus.b_data    = rsp_data_s;
    assign outstanding   = count_r;
    assign orphan_err    = orphan_r;

    // Steer the response by the head tag; with no tag held, swallow it
    always_comb begin
        bus.a_valid   = 1'b0;
        bus.b_valid   = 1'b0;
        bus.rsp_ready = 1'b1;
        if (empty_s) begin
            bus.a_valid   = 1'b0;
            bus.b_valid   = 1'b0;
            bus.rsp_ready = 1'b1;
        end else begin
            bus.a_valid   = bus.rsp_valid && !head_s;
            bus.b_valid   = bus.rsp_valid && head_s;
            bus.rsp_ready = head_s ? bus.b_ready : bus.a_ready;
        end
    end

    // Occupancy update for push, pop, both or neither
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Tag storage, wrapping pointers, occupancy and sticky orphan flag
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_r    <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            orphan_r <= 1'b0;
        end else begin
            if (push_s) begin
                tag_r[wr_ptr_r] <= bus.iss_sel;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_next_s;
            if (orphan_s) begin
                orphan_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_resp_router.sv
// Vector table plus randomized ordering run for mem_resp_router, with a
// scoreboard of expected destination ports.
module tb_mem_resp_router;
    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic [CW-1:0] outstanding;
    logic          orphan_err;

    mem_resp_router_if #(.n(N)) bus ();

    mem_resp_router #(.n(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .outstanding (outstanding),
        .orphan_err  (orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        iv;
        logic        isel;
        logic        rv;
        logic [31:0] rd;
        logic        ar;
        logic        br;
        logic        e_ir;
        logic        e_rr;
        logic        e_av;
        logic        e_bv;
        logic [2:0]  e_out;
        logic        e_orph;
    } vec_t;

    int   n_cmp = 0;
    int   n_err = 0;
    logic sb_q[$];
    vec_t tbl[$];

    function automatic vec_t mk(input string nm, input logic r, input logic iv, input logic isel,
                                input logic rv, input logic [31:0] rd, input logic ar, input logic br,
                                input logic e_ir, input logic e_rr, input logic e_av, input logic e_bv,
                                input logic [2:0] e_out, input logic e_orph);
        vec_t v;
        v.name = nm; v.rst = r; v.iv = iv; v.isel = isel; v.rv = rv; v.rd = rd;
        v.ar = ar; v.br = br; v.e_ir = e_ir; v.e_rr = e_rr; v.e_av = e_av; v.e_bv = e_bv;
        v.e_out = e_out; v.e_orph = e_orph;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive, check combinational and registered outputs, update scoreboard, clock
    task automatic step(input vec_t v);
        logic exp_port;
        rst            = v.rst;
        bus.iss_valid  = v.iv;
        bus.iss_sel    = v.isel;
        bus.rsp_valid  = v.rv;
        bus.rsp_data   = v.rd;
        bus.a_ready    = v.ar;
        bus.b_ready    = v.br;
        #2;
        chk({v.name, ".iss_ready"},   32'(bus.iss_ready), 32'(v.e_ir));
        chk({v.name, ".rsp_ready"},   32'(bus.rsp_ready), 32'(v.e_rr));
        chk({v.name, ".a_valid"},     32'(bus.a_valid),   32'(v.e_av));
        chk({v.name, ".b_valid"},     32'(bus.b_valid),   32'(v.e_bv));
        chk({v.name, ".outstanding"}, 32'(outstanding),   32'(v.e_out));
        chk({v.name, ".orphan_err"},  32'(orphan_err),    32'(v.e_orph));
        if (v.rv && v.e_rr && (v.e_av || v.e_bv)) begin
            if (sb_q.size() == 0) begin
                chk({v.name, ".sb_underflow"}, 32'd1, 32'd0);
            end else begin
                exp_port = sb_q.pop_front();
                chk({v.name, ".sb_port"}, 32'({bus.a_valid, bus.b_valid}),
                    exp_port ? 32'd1 : 32'd2);
                chk({v.name, ".sb_data"}, exp_port ? bus.b_data : bus.a_data, v.rd);
            end
        end
        if (v.iv && v.e_ir) begin
            sb_q.push_back(v.isel);
        end
        @(posedge clk);
        #1;
        if (v.rst) begin
            sb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        int   issued;
        logic head;
        logic iv, isel, rv, ar, br, e_rr, e_av, e_bv, e_ir, push, pop;
        logic [31:0] rd;

        rst = 1'b1;
        bus.iss_valid = 1'b0; bus.iss_sel = 1'b0; bus.rsp_valid = 1'b0;
        bus.rsp_data = 32'h0; bus.a_ready = 1'b1; bus.b_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        //                 name          rst  iv   sel  rv   data          ar   br   ir   rr   av   bv   out   orph
        tbl.push_back(mk("reset",       1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0));
        tbl.push_back(mk("ab_iss_a",    1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0));
        tbl.push_back(mk("ab_iss_b",    1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd1,1'b0));
        tbl.push_back(mk("ab_wait",     1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd2,1'b0));
        tbl.push_back(mk("ab_rsp_a",    1'b0,1'b0,1'b0,1'b1,32'h11111111, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,3'd2,1'b0));
        tbl.push_back(mk("ab_rsp_b",    1'b0,1'b0,1'b0,1'b1,32'h22222222, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,3'd1,1'b0));
        tbl.push_back(mk("ab_done",     1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0));
        tbl.push_back(mk("fill0",       1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0));
        tbl.push_back(mk("fill1",       1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd1,1'b0));
        tbl.push_back(mk("fill2",       1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd2,1'b0));
        tbl.push_back(mk("fill3",       1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd3,1'b0));
        tbl.push_back(mk("full_refuse", 1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,3'd4,1'b0));
        tbl.push_back(mk("full_pop",    1'b0,1'b0,1'b0,1'b1,32'hA0A0A0A0, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,3'd4,1'b0));
        tbl.push_back(mk("full_reopen", 1'b0,1'b0,1'b0,1'b1,32'hB1B1B1B1, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,3'd3,1'b0));
        tbl.push_back(mk("drain_a",     1'b0,1'b0,1'b0,1'b1,32'hA2A2A2A2, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,3'd2,1'b0));
        tbl.push_back(mk("drain_b",     1'b0,1'b0,1'b0,1'b1,32'hB3B3B3B3, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,3'd1,1'b0));
        tbl.push_back(mk("full_empty",  1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0));
        tbl.push_back(mk("bp_iss",      1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0));
        tbl.push_back(mk("bp_stall0",   1'b0,1'b0,1'b0,1'b1,32'h33333333, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,3'd1,1'b0));
        tbl.push_back(mk("bp_stall1",   1'b0,1'b0,1'b0,1'b1,32'h33333333, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,3'd1,1'b0));
        tbl.push_back(mk("bp_stall2",   1'b0,1'b0,1'b0,1'b1,32'h33333333, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,3'd1,1'b0));
        tbl.push_back(mk("bp_go",       1'b0,1'b0,1'b0,1'b1,32'h33333333, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,3'd1,1'b0));
        tbl.push_back(mk("bp_done",     1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0));
        tbl.push_back(mk("sp_iss0",     1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0));
        tbl.push_back(mk("sp_iss1",     1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd1,1'b0));
        tbl.push_back(mk("sp_both",     1'b0,1'b1,1'b0,1'b1,32'h44444444, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,3'd2,1'b0));
        tbl.push_back(mk("sp_hold",     1'b0,1'b0,1'b0,1'b1,32'h55555555, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,3'd2,1'b0));
        tbl.push_back(mk("sp_d1",       1'b0,1'b0,1'b0,1'b1,32'h66666666, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,3'd1,1'b0));
        tbl.push_back(mk("sp_d2",       1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0));
        tbl.push_back(mk("or_rsp",      1'b0,1'b0,1'b0,1'b1,32'h0000DEAD, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0));
        tbl.push_back(mk("or_set",      1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b1));
        tbl.push_back(mk("or_hold",     1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,3'd0,1'b1));
        tbl.push_back(mk("or_rst",      1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b1));
        tbl.push_back(mk("or_clr",      1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0));
        tbl.push_back(mk("po_both",     1'b0,1'b1,1'b1,1'b1,32'h77777777, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0));
        tbl.push_back(mk("po_chk",      1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd1,1'b1));
        tbl.push_back(mk("po_rsp",      1'b0,1'b0,1'b0,1'b1,32'h78787878, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,3'd1,1'b1));
        tbl.push_back(mk("po_rst",      1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b1));
        tbl.push_back(mk("po_clr",      1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0));
        tbl.push_back(mk("mr_iss0",     1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0));
        tbl.push_back(mk("mr_iss1",     1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd1,1'b0));
        tbl.push_back(mk("mr_iss2",     1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd2,1'b0));
        tbl.push_back(mk("mr_rst",      1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd3,1'b0));
        tbl.push_back(mk("mr_after",    1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0));
        tbl.push_back(mk("mr_orph",     1'b0,1'b0,1'b0,1'b1,32'h88888888, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0));
        tbl.push_back(mk("mr_set",      1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b1));
        tbl.push_back(mk("mr_rst2",     1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b1));

        foreach (tbl[i]) begin
            step(tbl[i]);
        end

        // Randomized ordering with pointer wrap, expectations from an independent occupancy model
        cnt    = 0;
        issued = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (issued == 2 * DEPTH && cnt == 0) begin
                break;
            end
            iv   = (issued < 2 * DEPTH) && ($urandom_range(0, 3) != 0);
            isel = 1'($urandom_range(0, 1));
            rv   = (cnt > 0) && ($urandom_range(0, 2) != 0);
            rd   = $urandom;
            ar   = ($urandom_range(0, 3) != 0);
            br   = ($urandom_range(0, 3) != 0);
            head = (cnt > 0) ? sb_q[0] : 1'b0;
            e_ir = (cnt != DEPTH);
            e_rr = (cnt == 0) ? 1'b1 : (head ? br : ar);
            e_av = rv && (cnt > 0) && !head;
            e_bv = rv && (cnt > 0) && head;
            push = iv && e_ir;
            pop  = rv && e_rr && (cnt > 0);
            step(mk($sformatf("rnd%0d", cyc), 1'b0, iv, isel, rv, rd, ar, br,
                    e_ir, e_rr, e_av, e_bv, 3'(cnt), 1'b0));
            cnt    = cnt + (push ? 1 : 0) - (pop ? 1 : 0);
            issued = issued + (push ? 1 : 0);
        end
        chk("rnd_completed_issues", 32'(issued), 32'(2 * DEPTH));
        chk("rnd_drained", 32'(cnt), 32'd0);
        step(mk("rnd_final", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
